// File: rtl/data_sram_resp_pkg.sv
// Shared constants for the data SRAM responder.
//   DATA_SRAM_ADDR_WD : default word-index width (array holds 2^N 32-bit words)
//   SRAM_OOR_DATA     : read data returned for an out-of-range access
package data_sram_resp_pkg;

  localparam int unsigned DATA_SRAM_ADDR_WD = 16;
  localparam logic [31:0] SRAM_OOR_DATA     = 32'hDEAD_BEEF;

endpackage

// File: rtl/sram_bytebank.sv
// One byte lane of the data SRAM: 8-bit wide, 2^ADDR_WIDTH deep, read-first.
// Ports:
//   clk   : clock, rising edge
//   en    : access this cycle (read always, write if we)
//   we    : write enable for this lane
//   addr  : word index
//   wdata : write byte
//   rdata : registered read byte (old contents on a write), held while en = 0
module sram_bytebank #(
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [7:0] mem [Depth];

  // No reset: maps onto block RAM; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder for the execute/memory stages.
// Samples the request every cycle, performs byte-lane writes into four byte
// banks, returns read data one cycle later, and keeps debug counters plus a
// sticky out-of-range flag.
// Ports:
//   clk, reset       : clock and synchronous active-high reset
//   data_sram_en     : access request
//   data_sram_wen    : byte write enables (0 = read)
//   data_sram_addr   : byte address, bits [1:0] ignored
//   data_sram_wdata  : write data
//   data_sram_rdata  : read data (read-first on writes), 1-cycle latency
//   sram_err         : sticky out-of-range flag
//   rd_cnt, wr_cnt   : accepted read / write access counters (wrapping)
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DATA_SRAM_ADDR_WD,
  parameter logic [31:0] OOR_DATA   = SRAM_OOR_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        sram_err,
  output logic [31:0] rd_cnt,
  output logic [31:0] wr_cnt
);

  logic [ADDR_WIDTH-1:0] idx;
  logic                  oor;
  logic                  is_wr;
  logic                  bank_en;
  logic [7:0]            bank_rdata [4];
  // oor_q steers the output mux; clr_q forces zero from reset until next access.
  logic                  oor_q;
  logic                  clr_q;
  logic                  unused_addr;

  assign idx         = data_sram_addr[ADDR_WIDTH+1:2];
  assign oor         = |data_sram_addr[31:ADDR_WIDTH+2];
  assign is_wr       = |data_sram_wen;
  assign bank_en     = data_sram_en & ~reset & ~oor;
  assign unused_addr = ^data_sram_addr[1:0];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    sram_bytebank #(
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk   (clk),
      .en    (bank_en),
      .we    (data_sram_wen[i]),
      .addr  (idx),
      .wdata (data_sram_wdata[8*i +: 8]),
      .rdata (bank_rdata[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      sram_err <= 1'b0;
      oor_q    <= 1'b0;
      clr_q    <= 1'b1;
    end else if (data_sram_en) begin
      oor_q <= oor;
      clr_q <= 1'b0;
      if (is_wr) begin
        wr_cnt <= wr_cnt + 32'd1;
      end else begin
        rd_cnt <= rd_cnt + 32'd1;
      end
      if (oor) begin
        sram_err <= 1'b1;
      end
    end
  end

  always_comb begin
    data_sram_rdata = {bank_rdata[3], bank_rdata[2], bank_rdata[1], bank_rdata[0]};
    if (clr_q) begin
      data_sram_rdata = '0;
    end else if (oor_q) begin
      data_sram_rdata = OOR_DATA;
    end
  end

endmodule

// File: tb/tb_data_sram_resp.sv
module tb_data_sram_resp;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        sram_err;
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  data_sram_resp dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .sram_err        (sram_err),
    .rd_cnt          (rd_cnt),
    .wr_cnt          (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: word-addressed memory and expected outputs.
  logic [31:0] mem_m [int];
  logic [31:0] exp_rdata;
  logic [31:0] exp_rd;
  logic [31:0] exp_wr;
  logic        exp_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus, update the model at the edge, compare after.
  task automatic step(input logic rst, input logic en, input logic [3:0] wen,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int          w;
    logic [31:0] old;
    logic [31:0] nw;
    bit          is_oor;
    reset           = rst;
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    @(posedge clk);
    if (rst) begin
      exp_rdata = 0;
      exp_rd    = 0;
      exp_wr    = 0;
      exp_err   = 0;
    end else if (en) begin
      is_oor = (addr >= 32'h0004_0000);
      w      = int'(addr / 4);
      if (is_oor) begin
        exp_rdata = 32'hDEAD_BEEF;
        exp_err   = 1;
      end else begin
        old       = mem_m.exists(w) ? mem_m[w] : 32'h0;
        exp_rdata = old;
        if (wen != 0) begin
          nw = old;
          for (int i = 0; i < 4; i++) begin
            if (wen[i]) nw[8*i +: 8] = wdata[8*i +: 8];
          end
          mem_m[w] = nw;
        end
      end
      if (wen != 0) exp_wr = exp_wr + 1;
      else          exp_rd = exp_rd + 1;
    end
    #1;
    check("rdata", data_sram_rdata, exp_rdata);
    check("rd_cnt", rd_cnt, exp_rd);
    check("wr_cnt", wr_cnt, exp_wr);
    check("sram_err", {31'b0, sram_err}, {31'b0, exp_err});
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] wen);
    step(1'b0, 1'b1, wen, addr, d);
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b0, 1'b1, 4'h0, addr, $urandom);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'($urandom), $urandom, $urandom);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  wen;
    exp_rdata = 0; exp_rd = 0; exp_wr = 0; exp_err = 0;
    // Reset state
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_err", {31'b0, sram_err}, 32'h0);

    // Preload words used below, then clear counters (array survives reset).
    wr(32'h0000_0000, 32'hCAFE_F00D, 4'hf);
    wr(32'h0000_0200, 32'hAABB_CCDD, 4'hf);
    wr(32'h0000_0300, 32'h0000_0000, 4'hf);
    step(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);

    // Full-word write/read
    wr(32'h0000_0100, 32'h1234_5678, 4'hf);
    rd(32'h0000_0100);
    check("full_rdata", data_sram_rdata, 32'h1234_5678);
    check("full_wr_cnt", wr_cnt, 32'd1);
    check("full_rd_cnt", rd_cnt, 32'd1);

    // Byte-lane merge
    wr(32'h0000_0200, 32'h1122_3344, 4'b0101);
    rd(32'h0000_0200);
    check("merge_rdata", data_sram_rdata, 32'hAA22_CC44);

    // Read-first on write
    wr(32'h0000_0300, 32'hFFFF_FFFF, 4'hf);
    check("rfirst_old", data_sram_rdata, 32'h0);
    rd(32'h0000_0300);
    check("rfirst_new", data_sram_rdata, 32'hFFFF_FFFF);

    // Out of range
    rd(32'h0004_0000);
    check("oor_rdata", data_sram_rdata, 32'hDEAD_BEEF);
    check("oor_err", {31'b0, sram_err}, 32'h1);
    wr(32'h0004_0000, 32'h7777_7777, 4'hf);
    check("oor_wr_cnt", wr_cnt, 32'd4);
    check("oor_rd_cnt", rd_cnt, 32'd4);
    rd(32'h0000_0000);
    check("oor_word0", data_sram_rdata, 32'hCAFE_F00D);
    check("oor_sticky", {31'b0, sram_err}, 32'h1);

    // Idle hold
    rd(32'h0000_0100);
    for (int i = 0; i < 5; i++) idle();
    check("idle_rdata", data_sram_rdata, 32'h1234_5678);
    check("idle_rd_cnt", rd_cnt, 32'd6);

    // Reset mid-sequence: the presented write must be dropped
    step(1'b1, 1'b1, 4'hf, 32'h0000_0100, 32'h5555_5555);
    check("rst_mid_rdata", data_sram_rdata, 32'h0);
    check("rst_mid_wr_cnt", wr_cnt, 32'd0);
    idle();
    check("rst_mid_hold", data_sram_rdata, 32'h0);
    rd(32'h0000_0100);
    check("rst_mid_old", data_sram_rdata, 32'h1234_5678);

    // Randomized traffic over a small window plus out-of-range hits
    for (int i = 0; i < 16; i++) wr(32'h1000 + 4 * i, $urandom, 4'hf);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom;
        if (a[31:18] == 0) a[18] = 1'b1;
      end else begin
        a = 32'h1000 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      end
      wen = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, wen, a, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
